// File: rtl/vx_ag_tcu_fedp_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : vx_ag_tcu_fedp_issuer
//  Purpose  : Sequences one dot-product job through an external fused
//             element dot-product (FEDP) unit. A job starts from an fp32
//             accumulator and consumes req_steps K-chunks (N operand words
//             of A and B each). For each chunk the FEDP is enabled for
//             FEDP_LATENCY cycles, and its result is folded back into the
//             accumulator. The final accumulator is returned on rsp_*.
//  Ports    : clk, reset (async, active-low)
//             req_*   job request  (formats, step count, initial acc)
//             op_*    K-chunk operand stream (A row / B column)
//             fedp_*  drive to / result from the FEDP unit
//             rsp_*   job response (result word + error flag)
//  Revision : 1.0  initial release
// ============================================================================
module vx_ag_tcu_fedp_issuer #(
    parameter  int N            = 4,
    parameter  int MAX_STEPS    = 8,
    parameter  int FEDP_LATENCY = 4,
    localparam int STEPW        = $clog2(MAX_STEPS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    // job request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_fmt_s,
    input  logic [2:0]        req_fmt_d,
    input  logic [STEPW-1:0]  req_steps,
    input  logic [31:0]       req_c,
    // operand chunk stream
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [N*32-1:0]   op_a,
    input  logic [N*32-1:0]   op_b,
    // FEDP unit
    output logic              fedp_enable,
    output logic [2:0]        fedp_fmt_s,
    output logic [2:0]        fedp_fmt_d,
    output logic [N*32-1:0]   fedp_a_row,
    output logic [N*32-1:0]   fedp_b_col,
    output logic [31:0]       fedp_c_val,
    input  logic [31:0]       fedp_d_val,
    // job response
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_d,
    output logic              rsp_err
);

    localparam int          WAITW     = $clog2(FEDP_LATENCY + 1);
    localparam logic [31:0] C_QNAN    = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [2:0]          r_fmt_s;
    logic [2:0]          r_fmt_d;
    logic [STEPW-1:0]    r_steps;
    logic [STEPW-1:0]    r_step_cnt;
    logic [WAITW-1:0]    r_wait_cnt;
    logic [31:0]         r_acc;
    logic                r_rsp_err;
    logic [N*32-1:0]     r_op_a;
    logic [N*32-1:0]     r_op_b;

    logic                w_req_bad;
    logic [STEPW-1:0]    w_step_inc;

    // Unsupported source format or an over-long job is answered with a
    // quiet NaN instead of being issued.
    assign w_req_bad  = !((req_fmt_s == 3'd1) || (req_fmt_s == 3'd2))
                        || (req_steps > STEPW'(MAX_STEPS));
    assign w_step_inc = r_step_cnt + 1'b1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake/enable outputs. Outputs depend on the
    // state register only, so no input reaches them combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        op_ready     = 1'b0;
        fedp_enable  = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_bad || (req_steps == '0)) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                fedp_enable = 1'b1;
                if (r_wait_cnt == WAITW'(FEDP_LATENCY - 1)) begin
                    w_next_state = S_CAPT;
                end
            end
            S_CAPT: begin
                w_next_state = (w_step_inc == r_steps) ? S_RESP : S_ISSUE;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fmt_s    <= '0;
            r_fmt_d    <= '0;
            r_steps    <= '0;
            r_step_cnt <= '0;
            r_wait_cnt <= '0;
            r_acc      <= '0;
            r_rsp_err  <= 1'b0;
            r_op_a     <= '0;
            r_op_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_fmt_s    <= req_fmt_s;
                        r_fmt_d    <= req_fmt_d;
                        r_steps    <= req_steps;
                        r_step_cnt <= '0;
                        r_acc      <= w_req_bad ? C_QNAN : req_c;
                        r_rsp_err  <= w_req_bad;
                    end
                end
                S_ISSUE: begin
                    if (op_valid) begin
                        r_op_a     <= op_a;
                        r_op_b     <= op_b;
                        r_wait_cnt <= '0;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                S_CAPT: begin
                    r_acc      <= fedp_d_val;
                    r_step_cnt <= w_step_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // FEDP operands come straight from registers, so they stay stable for
    // the whole WAIT/CAPT window of a step.
    assign fedp_fmt_s = r_fmt_s;
    assign fedp_fmt_d = r_fmt_d;
    assign fedp_a_row = r_op_a;
    assign fedp_b_col = r_op_b;
    assign fedp_c_val = r_acc;
    assign rsp_d      = r_acc;
    assign rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_vx_ag_tcu_fedp_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_ag_tcu_fedp_issuer
//  Purpose  : Self-checking bench for vx_ag_tcu_fedp_issuer with a
//             behavioural FEDP (real-arithmetic dot product behind an
//             enable-gated pipeline) and a job-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vx_ag_tcu_fedp_issuer;

    localparam int          N            = 4;
    localparam int          MAX_STEPS    = 8;
    localparam int          FEDP_LATENCY = 4;
    localparam int          STEPW        = $clog2(MAX_STEPS + 1);
    localparam logic [31:0] C_QNAN       = 32'h7FC0_0000;

    logic              clk;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmt_s;
    logic [2:0]        req_fmt_d;
    logic [STEPW-1:0]  req_steps;
    logic [31:0]       req_c;
    logic              op_valid;
    logic              op_ready;
    logic [N*32-1:0]   op_a;
    logic [N*32-1:0]   op_b;
    logic              fedp_enable;
    logic [2:0]        fedp_fmt_s;
    logic [2:0]        fedp_fmt_d;
    logic [N*32-1:0]   fedp_a_row;
    logic [N*32-1:0]   fedp_b_col;
    logic [31:0]       fedp_c_val;
    logic [31:0]       fedp_d_val;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_d;
    logic              rsp_err;

    vx_ag_tcu_fedp_issuer #(
        .N            (N),
        .MAX_STEPS    (MAX_STEPS),
        .FEDP_LATENCY (FEDP_LATENCY)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fmt_s   (req_fmt_s),
        .req_fmt_d   (req_fmt_d),
        .req_steps   (req_steps),
        .req_c       (req_c),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .fedp_enable (fedp_enable),
        .fedp_fmt_s  (fedp_fmt_s),
        .fedp_fmt_d  (fedp_fmt_d),
        .fedp_a_row  (fedp_a_row),
        .fedp_b_col  (fedp_b_col),
        .fedp_c_val  (fedp_c_val),
        .fedp_d_val  (fedp_d_val),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_d       (rsp_d),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int en_cnt = 0;
    int or_cnt = 0;
    int rv_cnt = 0;

    logic [N*32-1:0] q_a [MAX_STEPS+1];
    logic [N*32-1:0] q_b [MAX_STEPS+1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- floating-point helpers (model side) ----------------
    function automatic real half_to_real(input logic [2:0] fmt, input logic [15:0] h);
        int e;
        if (fmt == 3'd2) begin
            e = int'(h[14:7]);
            if (e == 0) return 0.0;
            return $bitstoreal({h[15], 11'(e - 127 + 1023), h[6:0], 45'b0});
        end
        e = int'(h[14:10]);
        if (e == 0) return 0.0;
        return $bitstoreal({h[15], 11'(e - 15 + 1023), h[9:0], 42'b0});
    endfunction

    function automatic real f32_to_real(input logic [31:0] w);
        int e;
        e = int'(w[30:23]);
        if (e == 0) return 0.0;
        return $bitstoreal({w[31], 11'(e - 127 + 1023), w[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        int          e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = int'(b[62:52]);
        return {b[63], 8'(e - 1023 + 127), b[51:29]};
    endfunction

    // d = c + sum over all 2N half-precision lanes of a*b
    function automatic logic [31:0] fedp_fn(input logic [2:0] fmt, input logic [31:0] c,
                                            input logic [N*32-1:0] a, input logic [N*32-1:0] b);
        real acc;
        acc = f32_to_real(c);
        for (int i = 0; i < 2 * N; i++)
            acc = acc + half_to_real(fmt, a[16*i +: 16]) * half_to_real(fmt, b[16*i +: 16]);
        return real_to_f32(acc);
    endfunction

    // ---------------- behavioural FEDP unit ----------------
    logic [31:0] pipe [FEDP_LATENCY];
    always @(posedge clk) begin
        if (fedp_enable) begin
            pipe[0] <= fedp_fn(fedp_fmt_s, fedp_c_val, fedp_a_row, fedp_b_col);
            for (int i = 1; i < FEDP_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign fedp_d_val = pipe[FEDP_LATENCY-1];

    // ---------------- monitors ----------------
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (fedp_enable) en_cnt <= en_cnt + 1;
        if (op_ready)    or_cnt <= or_cnt + 1;
        if (rsp_valid)   rv_cnt <= rv_cnt + 1;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] rand_half(input logic [2:0] fmt);
        logic [2:0] m;
        m = 3'($urandom);
        if ($urandom_range(0, 9) == 0) return 16'h0000;
        if (fmt == 3'd2)
            return {1'($urandom), 8'($urandom_range(124, 130)), m, 4'b0};
        return {1'($urandom), 5'($urandom_range(12, 18)), m, 7'b0};
    endfunction

    task automatic fill_random(input logic [2:0] fmt);
        for (int k = 0; k <= MAX_STEPS; k++)
            for (int i = 0; i < 2 * N; i++) begin
                q_a[k][16*i +: 16] = rand_half(fmt);
                q_b[k][16*i +: 16] = rand_half(fmt);
            end
    endtask

    task automatic fill_const();
        for (int k = 0; k <= MAX_STEPS; k++)
            for (int i = 0; i < N; i++) begin
                q_a[k][32*i +: 32] = 32'h3C00_3C00;
                q_b[k][32*i +: 32] = 32'h4000_4000;
            end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"},   64'(req_ready),   64'd1);
        chk({tag, ".op_ready"},    64'(op_ready),    64'd0);
        chk({tag, ".fedp_enable"}, 64'(fedp_enable), 64'd0);
        chk({tag, ".rsp_valid"},   64'(rsp_valid),   64'd0);
        chk({tag, ".rsp_err"},     64'(rsp_err),     64'd0);
        chk({tag, ".rsp_d"},       64'(rsp_d),       64'd0);
        chk({tag, ".fedp_c_val"},  64'(fedp_c_val),  64'd0);
        chk({tag, ".fedp_a_row"},  64'(fedp_a_row == '0), 64'd1);
    endtask

    // One complete job: request, operand chunks (op_valid held high so
    // back-to-back steps run at full rate), response with optional
    // backpressure. probe drives a legal new request during the response
    // handshake cycle, which must not be taken.
    task automatic run_job(input string tag, input logic [2:0] fs, input logic [STEPW-1:0] st,
                           input logic [31:0] c, input int hold, input bit probe,
                           output logic [31:0] got_d);
        logic [31:0] exp_d;
        logic        exp_err;
        bit          legal;
        int          n_ops, en0, or0, e_r, e_prev, e_o, t;

        legal = ((fs == 3'd1) || (fs == 3'd2)) && (int'(st) <= MAX_STEPS);
        if (!legal) begin
            exp_d   = C_QNAN;
            exp_err = 1'b1;
        end else begin
            exp_d   = c;
            exp_err = 1'b0;
            for (int k = 0; k < int'(st); k++) exp_d = fedp_fn(fs, exp_d, q_a[k], q_b[k]);
        end
        n_ops = legal ? int'(st) : 0;
        en0   = en_cnt;
        or0   = or_cnt;

        op_valid  = 1'b1;
        op_a      = q_a[0];
        op_b      = q_b[0];
        req_valid = 1'b1;
        req_fmt_s = fs;
        req_fmt_d = 3'd0;
        req_steps = st;
        req_c     = c;
        t = 0;
        while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) chk({tag, ".req_timeout"}, 64'd1, 64'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        e_r       = cyc;
        e_prev    = e_r;

        for (int k = 0; k < n_ops; k++) begin
            t = 0;
            while (!op_ready && t < 50) begin @(posedge clk); #1; t++; end
            if (t >= 50) chk({tag, ".op_timeout"}, 64'd1, 64'd0);
            @(posedge clk); #1;
            e_o = cyc;
            if (k == 0) chk({tag, ".first_op_cycle"}, 64'(e_o - e_r), 64'd1);
            else        chk({tag, ".op_gap"}, 64'(e_o - e_prev), 64'(FEDP_LATENCY + 2));
            e_prev = e_o;
            if (k + 1 < n_ops) begin
                op_a = q_a[k+1];
                op_b = q_b[k+1];
            end
        end
        op_valid = 1'b0;

        t = 0;
        while (!rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) chk({tag, ".rsp_timeout"}, 64'd1, 64'd0);
        chk({tag, ".rsp_latency"}, 64'(cyc - e_prev), 64'(n_ops == 0 ? 0 : FEDP_LATENCY + 1));
        chk({tag, ".rsp_d"},   64'(rsp_d),   64'(exp_d));
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        got_d = rsp_d;

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".hold_d"},     64'(rsp_d),     64'(exp_d));
            chk({tag, ".hold_rdy"},   64'(req_ready), 64'd0);
        end

        rsp_ready = 1'b1;
        if (probe) begin
            req_valid = 1'b1;
            req_fmt_s = 3'd1;
            req_steps = STEPW'(1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk({tag, ".post_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".post_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, ".enable_cycles"},  64'(en_cnt - en0), 64'(n_ops * FEDP_LATENCY));
        chk({tag, ".op_ready_cycles"}, 64'(or_cnt - or0), 64'(n_ops));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic [2:0]  fs;
        int          r, rv0, t;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_fmt_s = '0;
        req_fmt_d = '0;
        req_steps = '0;
        req_c     = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        rsp_ready = 1'b0;

        #2;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("post_reset.req_ready", 64'(req_ready), 64'd1);

        fill_const();
        run_job("one_step", 3'd1, STEPW'(1), 32'h0, 0, 1'b0, d);
        chk("one_step.value", 64'(d), 64'h4180_0000);
        run_job("two_step", 3'd1, STEPW'(2), 32'h3F80_0000, 0, 1'b0, d);
        chk("two_step.value", 64'(d), 64'h4204_0000);
        run_job("zero_step", 3'd1, STEPW'(0), 32'h4049_0FDB, 0, 1'b0, d);
        chk("zero_step.value", 64'(d), 64'h4049_0FDB);
        run_job("bad_fmt", 3'd3, STEPW'(2), 32'h3F80_0000, 0, 1'b0, d);
        chk("bad_fmt.value", 64'(d), 64'(C_QNAN));
        run_job("too_many", 3'd2, STEPW'(MAX_STEPS + 1), 32'h3F80_0000, 0, 1'b0, d);
        run_job("max_steps", 3'd1, STEPW'(MAX_STEPS), 32'h0, 0, 1'b0, d);
        run_job("backpressure", 3'd1, STEPW'(1), 32'h0, 10, 1'b1, d);

        // Reset during the WAIT phase of step 2 of a 2-step job.
        op_valid  = 1'b1;
        op_a      = q_a[0];
        op_b      = q_b[0];
        req_valid = 1'b1;
        req_fmt_s = 3'd1;
        req_steps = STEPW'(2);
        req_c     = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!op_ready && t < 50) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort.in_wait", 64'(fedp_enable), 64'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        rv0 = rv_cnt;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("abort.first_cycle_idle", 64'(req_ready), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("abort.no_response", 64'(rv_cnt - rv0), 64'd0);
        run_job("after_abort", 3'd1, STEPW'(1), 32'h0, 0, 1'b0, d);
        chk("after_abort.value", 64'(d), 64'h4180_0000);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            r  = $urandom_range(0, 9);
            fs = (r < 4) ? 3'd1 : (r < 8) ? 3'd2 : 3'($urandom_range(0, 7));
            fill_random((fs == 3'd2) ? 3'd2 : 3'd1);
            run_job("random", fs, STEPW'($urandom_range(0, MAX_STEPS + 1)),
                    {1'($urandom), 8'($urandom_range(124, 132)), 23'($urandom) & 23'h7F_FC00},
                    $urandom_range(0, 3), 1'($urandom), d);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/vx_ag_tcu_fedp_issuer.md
VX_AG_TCU_FEDP_ISSUER -- requirements
Module: VX_ag_tcu_fedp_issuer

Interface
REQ-001 SHALL have parameter N, default 4: 32-bit operand words per dot-product step (FEDP width).
REQ-002 SHALL have parameter MAX_STEPS, default 8: maximum K-chunks per request; STEPW = $clog2(MAX_STEPS+1).
REQ-003 SHALL have parameter FEDP_LATENCY, default 4: enabled cycles from FEDP input to d_val.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid/req_ready, input/output, 1/1: job request handshake.
REQ-007 SHALL have ports req_fmt_s, req_fmt_d, req_steps, req_c, input, 3/3/STEPW/32: source format (1=fp16, 2=bf16), dest format, step count, fp32 initial accumulator.
REQ-008 SHALL have ports op_valid/op_ready, input/output, 1/1, plus op_a, op_b, input, N*32 each: one K-chunk of A row and B column.
REQ-009 SHALL have ports fedp_enable, fedp_fmt_s, fedp_fmt_d, fedp_a_row, fedp_b_col, fedp_c_val, output, 1/3/3/N*32/N*32/32: drive the FEDP.
REQ-010 SHALL have port fedp_d_val, input, 32: FEDP result.
REQ-011 SHALL have ports rsp_valid/rsp_ready, output/input, 1/1, plus rsp_d (32) and rsp_err (1), output: job result.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, CAPT, RESP.
REQ-013 IDLE: req_ready=1; on req_valid, latch fmt_s, fmt_d, steps, acc<=req_c, step_cnt<=0.
REQ-014 On accept, fmt_s not in {1,2} SHALL go to RESP with rsp_d=32'h7FC00000, rsp_err=1.
REQ-015 On accept, req_steps==0 SHALL go to RESP with rsp_d=req_c, rsp_err=0.
REQ-016 On accept, req_steps>MAX_STEPS SHALL be treated as illegal: RESP with 32'h7FC00000, rsp_err=1.
REQ-017 Otherwise SHALL go to ISSUE.
REQ-018 ISSUE: op_ready=1; on op_valid, latch op_a/op_b into operand registers, go to WAIT, wait_cnt<=0.
REQ-019 op_ready SHALL be 0 in every state except ISSUE.
REQ-020 fedp_a_row/fedp_b_col SHALL come from operand registers, fedp_c_val from acc, fedp_fmt_* from latched formats; all stable during WAIT and CAPT.
REQ-021 WAIT: fedp_enable=1 for exactly FEDP_LATENCY consecutive cycles, then CAPT.
REQ-022 fedp_enable SHALL be 0 in all other states.
REQ-023 CAPT: acc<=fedp_d_val, step_cnt<=step_cnt+1; if incremented count equals steps go to RESP, else ISSUE.
REQ-024 Per-step latency from op handshake cycle T: fedp_enable high T+1..T+FEDP_LATENCY, CAPT in T+FEDP_LATENCY+1, next op_ready earliest T+FEDP_LATENCY+2.
REQ-025 RESP: rsp_valid=1, rsp_d=acc, rsp_err as set; rsp_d/rsp_err SHALL be held stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
REQ-026 req_ready SHALL be 0 outside IDLE; a new request SHALL NOT be accepted in the RESP handshake cycle.
REQ-027 op_valid held across a step boundary SHALL NOT be consumed twice; each handshake consumes exactly one chunk.
REQ-028 No combinational path from rsp_ready or op_valid to req_ready, op_ready or fedp_* outputs.

Reset
REQ-029 reset low SHALL asynchronously force IDLE, req_ready=1 after release, op_ready=0, fedp_enable=0, rsp_valid=0, rsp_err=0, acc=0, step_cnt=0, wait_cnt=0, operand registers=0.
REQ-030 reset asserted mid-job (any state) SHALL abandon the job with no rsp_valid pulse; first cycle after release behaves as IDLE.

Verification (bench uses a behavioural FEDP model, FEDP_LATENCY=4, N=4)
REQ-031 fmt_s=1, steps=1, c=0, op_a words 32'h3C003C00 (1.0,1.0), op_b words 32'h40004000 (2.0,2.0) -> rsp_d=32'h41800000 (16.0), rsp_err=0, fedp_enable high exactly 4 cycles.
REQ-032 Same operands, steps=2, c=32'h3F800000 -> rsp_d=32'h42040000 (33.0); second op_ready exactly 6 cycles after first handshake.
REQ-033 steps=0, c=32'h40490FDB -> rsp_valid next cycle with rsp_d=32'h40490FDB, fedp_enable never asserted.
REQ-034 fmt_s=3 -> rsp_d=32'h7FC00000, rsp_err=1, op_ready never asserted.
REQ-035 rsp_ready held low 10 cycles -> rsp_valid and rsp_d stable throughout, req_ready=0 until handshake.
REQ-036 reset low during WAIT of step 2 -> all outputs at reset values immediately, no response; following 1-step job completes correctly.
